data_merge: RTL and testbench
=============================

# data_merge

Reassembles the windowed stream produced by the team's windowing/segmentation stage back into one continuous frame. Input windows of up to MAX_CNT samples each end with tlast; the final window of a frame is flagged with tuser. The block concatenates the windows, optionally re-inserts SKIP_MAX zero samples at the frame start, and emits a single frame-level tlast. It sits at the back end of the processing chain, after per-window processing, and feeds frame-oriented consumers.

## Interface
- MAX_CNT, 100, nominal samples per window
- SKIP_MAX, 50, number of zero samples prepended per frame when PAD_EN=1
- PAD_EN, 1, 1 = re-insert SKIP_MAX zero samples at frame start; 0 = no padding

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  76  sample, {real, imag} packed as in the upstream stage
- s_axis_tvalid  in  1  input sample valid
- s_axis_tlast  in  1  last sample of a window
- s_axis_tuser  in  1  qualifies tlast: this window is the last of the frame (sampled only with tlast)
- s_axis_tready  out  1  input accept
- m_axis_tdata  out  76  reassembled sample
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last sample of the frame
- m_axis_tready  in  1  downstream ready
- window_cnt  out  16  windows accepted in the current frame
- frame_len  out  32  samples (including pad) emitted in the current or most recent frame
- err_long  out  1  one-cycle pulse: MAX_CNT samples accepted without tlast
- err_short  out  1  one-cycle pulse: tlast before MAX_CNT samples on a non-final window

## Operation
- Output is one register stage: m_axis_* are registers. The stage loads when (~m_axis_tvalid | m_axis_tready). s_axis_tready = load condition AND state==PASS.
- FSM states: IDLE, PAD, PASS.
  - IDLE: s_axis_tready=0. If s_axis_tvalid=1: go to PAD when PAD_EN=1 and SKIP_MAX>0; otherwise go to PASS.
  - PAD: on each load cycle, emit tdata=0, tlast=0, and increment pad_cnt. After SKIP_MAX emitted samples, go to PASS. Input is not accepted in PAD.
  - PASS: each accepted input is copied to the output register, with m_axis_tlast = s_axis_tlast & s_axis_tuser. An accepted sample with frame-end (tlast & tuser) moves to IDLE.
- samp_cnt counts accepted samples within the current window. It clears on an accepted tlast.
  - If an accepted sample has samp_cnt==MAX_CNT-1 and tlast=0: pulse err_long, clear samp_cnt (forced window boundary, counted in window_cnt). Data still passes through unchanged.
  - If an accepted tlast has samp_cnt<MAX_CNT-1 and tuser=0: pulse err_short. Data passes through. A short final window (tuser=1) is legal.
- window_cnt:
  - increments on every accepted tlast or forced boundary;
  - clears on the IDLE→PAD/PASS transition;
  - saturates at 16'hFFFF.
- frame_len:
  - increments on every output load (pad or data);
  - clears on the IDLE exit transition;
  - holds its final value in IDLE;
  - wraps at 2^32.
- A single-sample frame (tlast=tuser=1 on the first sample) is legal: pad (if enabled), then 1 sample, then IDLE.

## Timing
- Reset (rst_n=0 at a clk edge):
  - outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, window_cnt=0, frame_len=0, err_long=0, err_short=0;
  - internal: state=IDLE, samp_cnt=0, pad_cnt=0.
  - Reset mid-frame discards the output register contents and all counts; no tlast is emitted for the aborted frame.
- Latency: an input accepted at edge N is visible on m_axis at N+1.
- Throughput: 1 sample/cycle while m_axis_tready=1.
- IDLE detection costs one cycle: first pad (or data) output appears 2 cycles after tvalid rises in IDLE.
- PAD with m_axis_tready=1 throughout occupies exactly SKIP_MAX cycles. The first data sample is accepted in the cycle after the last pad load.
- m_axis_tdata/tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- The frame-end sample and the next frame's IDLE detect never overlap: at least one idle cycle separates frames on s_axis_tready.
- err_long/err_short are asserted in the cycle after the offending accept, and last one cycle.

## Test plan
- MAX_CNT=100, SKIP_MAX=50, PAD_EN=1, 3 full windows, tuser on the third tlast, m_axis_tready=1:
  - output is 50 zeros then 300 samples in order;
  - single m_axis_tlast on output #350;
  - frame_len=350, window_cnt=3, no error pulses.
- Same frame with m_axis_tready toggling 1/0 every cycle:
  - identical output sequence, data held during stalls;
  - no drops or duplicates.
- Short final window (100 + 37 samples, tuser on the 2nd tlast), PAD_EN=0:
  - 137 samples out, tlast on #137;
  - window_cnt=2, no error.
- Non-final window of 60 samples:
  - err_short pulses once;
  - data passes and the frame continues.
- A 150-sample window with no tlast:
  - err_long pulses once at sample 100;
  - window_cnt increments and samp_cnt restarts.
- Reset asserted at sample 120 of a frame:
  - all outputs zero on the next edge;
  - a fresh frame then reassembles correctly with 50-zero pad.

Source files
------------

// File: rtl/data_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_merge: concatenates per-window streams into one frame with optional   |
// | zero padding at frame start and a single frame-level tlast.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_merge #(
  parameter int MAX_CNT  = 100,
  parameter int SKIP_MAX = 50,
  parameter int PAD_EN   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [75:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [75:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] window_cnt,
  output logic [31:0] frame_len,
  output logic        err_long,
  output logic        err_short
);

  localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int PAD_W = (SKIP_MAX > 0) ? $clog2(SKIP_MAX + 1) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_PAD  = 2'd1;
  localparam logic [1:0] c_PASS = 2'd2;

  localparam logic [CNT_W-1:0] c_LAST_SAMP = CNT_W'(MAX_CNT - 1);
  localparam logic [PAD_W-1:0] c_LAST_PAD  = PAD_W'(SKIP_MAX - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] samp_cnt_q;
  logic [PAD_W-1:0] pad_cnt_q;
  logic [75:0]      tdata_q;
  logic             tvalid_q, tlast_q;
  logic [15:0]      window_cnt_q;
  logic [31:0]      frame_len_q;
  logic             err_long_q, err_short_q;

  logic w_load, w_accept, w_pad_load, w_idle_exit, w_pad_go;
  logic w_samp_last, w_boundary;

  generate
    if (PAD_EN != 0 && SKIP_MAX > 0) begin : g_pad
      assign w_pad_go = 1'b1;
    end else begin : g_nopad
      assign w_pad_go = 1'b0;
    end
  endgenerate

  assign w_load      = ~tvalid_q | m_axis_tready;
  assign w_samp_last = (samp_cnt_q == c_LAST_SAMP);
  // A window ends on tlast or when MAX_CNT samples arrive without one.
  assign w_boundary  = w_accept & (s_axis_tlast | w_samp_last);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (s_axis_tvalid) state_d = w_pad_go ? c_PAD : c_PASS;
      c_PAD:  if (w_load && pad_cnt_q == c_LAST_PAD) state_d = c_PASS;
      c_PASS: if (w_accept && s_axis_tlast && s_axis_tuser) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = w_load & (state_q == c_PASS);
    w_accept      = s_axis_tvalid & s_axis_tready;
    w_pad_load    = w_load & (state_q == c_PAD);
    w_idle_exit   = (state_q == c_IDLE) & s_axis_tvalid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      samp_cnt_q   <= '0;
      pad_cnt_q    <= '0;
      window_cnt_q <= '0;
      frame_len_q  <= '0;
      err_long_q   <= 1'b0;
      err_short_q  <= 1'b0;
    end else begin
      if (w_load) begin
        if (w_pad_load) begin
          tvalid_q <= 1'b1;
          tdata_q  <= '0;
          tlast_q  <= 1'b0;
        end else if (w_accept) begin
          tvalid_q <= 1'b1;
          tdata_q  <= s_axis_tdata;
          tlast_q  <= s_axis_tlast & s_axis_tuser;
        end else begin
          tvalid_q <= 1'b0;
        end
      end

      err_long_q  <= w_accept & ~s_axis_tlast & w_samp_last;
      err_short_q <= w_accept & s_axis_tlast & ~s_axis_tuser & (samp_cnt_q < c_LAST_SAMP);

      if (w_idle_exit)     samp_cnt_q <= '0;
      else if (w_boundary) samp_cnt_q <= '0;
      else if (w_accept)   samp_cnt_q <= samp_cnt_q + 1'b1;

      if (w_idle_exit)     pad_cnt_q <= '0;
      else if (w_pad_load) pad_cnt_q <= pad_cnt_q + 1'b1;

      if (w_idle_exit) window_cnt_q <= '0;
      else if (w_boundary && window_cnt_q != 16'hFFFF) window_cnt_q <= window_cnt_q + 16'd1;

      if (w_idle_exit) frame_len_q <= '0;
      else if (w_pad_load || w_accept) frame_len_q <= frame_len_q + 32'd1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign window_cnt    = window_cnt_q;
  assign frame_len     = frame_len_q;
  assign err_long      = err_long_q;
  assign err_short     = err_short_q;

endmodule
`default_nettype wire

// File: tb/tb_data_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_merge: directed frames through a padded and an unpadded instance.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_data_merge;

  localparam int SKIP = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [75:0] tdata = '0;
  logic tv = 1'b0, tl = 1'b0, tu = 1'b0, m_rdy = 1'b1, sel_np = 1'b0;

  logic        p_tv, p_srdy, p_mv, p_ml, p_el, p_es;
  logic [75:0] p_md;
  logic [15:0] p_wc;
  logic [31:0] p_fl;
  logic        n_tv, n_srdy, n_mv, n_ml, n_el, n_es;
  logic [75:0] n_md;
  logic [15:0] n_wc;
  logic [31:0] n_fl;

  assign p_tv = tv & ~sel_np;
  assign n_tv = tv & sel_np;

  data_merge #(.MAX_CNT(100), .SKIP_MAX(SKIP), .PAD_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(p_tv), .s_axis_tlast(tl), .s_axis_tuser(tu),
    .s_axis_tready(p_srdy),
    .m_axis_tdata(p_md), .m_axis_tvalid(p_mv), .m_axis_tlast(p_ml), .m_axis_tready(m_rdy),
    .window_cnt(p_wc), .frame_len(p_fl), .err_long(p_el), .err_short(p_es)
  );

  data_merge #(.MAX_CNT(100), .SKIP_MAX(SKIP), .PAD_EN(0)) u_dut_np (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(n_tv), .s_axis_tlast(tl), .s_axis_tuser(tu),
    .s_axis_tready(n_srdy),
    .m_axis_tdata(n_md), .m_axis_tvalid(n_mv), .m_axis_tlast(n_ml), .m_axis_tready(m_rdy),
    .window_cnt(n_wc), .frame_len(n_fl), .err_long(n_el), .err_short(n_es)
  );

  logic        s_rdy, m_v, m_l, e_l, e_s;
  logic [75:0] m_d;
  logic [15:0] wc;
  logic [31:0] fl;
  assign s_rdy = sel_np ? n_srdy : p_srdy;
  assign m_v   = sel_np ? n_mv : p_mv;
  assign m_l   = sel_np ? n_ml : p_ml;
  assign m_d   = sel_np ? n_md : p_md;
  assign wc    = sel_np ? n_wc : p_wc;
  assign fl    = sel_np ? n_fl : p_fl;
  assign e_l   = sel_np ? n_el : p_el;
  assign e_s   = sel_np ? n_es : p_es;

  int n_checks = 0;
  int n_errors = 0;
  logic [77:0] in_q[$];   // {tlast, tuser, tdata}
  logic [76:0] exp_q[$];  // {m_tlast, m_tdata}
  logic [76:0] out_q[$];
  int g_base = 1;
  int n_el_seen, n_es_seen, hold_bad, cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic add_pad(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  // One window of n samples; tlast/tuser placed on the final sample.
  task automatic add_win(input int n, input bit last_t, input bit user_t);
    logic [75:0] d;
    bit l;
    for (int i = 0; i < n; i++) begin
      d = {12'hA5A, 32'(g_base), ~32'(g_base)};
      g_base++;
      l = (i == n - 1) && last_t;
      in_q.push_back({l, l && user_t, d});
      exp_q.push_back({l && user_t, d});
    end
  endtask

  task automatic run_frame(input bit toggle, input int stop_n);
    bit done = 0;
    bit prev_stall = 0;
    logic [76:0] held = '0;
    cyc = 0; n_el_seen = 0; n_es_seen = 0; hold_bad = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      m_rdy = toggle ? ~m_rdy : 1'b1;
      if (in_q.size() > 0) begin
        tv = 1'b1; {tl, tu, tdata} = in_q[0];
      end else begin
        tv = 1'b0; tl = 1'b0; tu = 1'b0;
      end
      #1;
      if (prev_stall && {m_l, m_d} !== held) hold_bad++;
      prev_stall = m_v & ~m_rdy;
      held = {m_l, m_d};
      if (tv && s_rdy) void'(in_q.pop_front());
      if (m_v && m_rdy) begin
        out_q.push_back({m_l, m_d});
        if (m_l || (stop_n > 0 && out_q.size() == stop_n)) done = 1;
      end
      if (e_l) n_el_seen++;
      if (e_s) n_es_seen++;
      @(posedge clk);
      cyc++;
    end
    tv = 1'b0;
    chk("frame_timeout", 64'(done), 64'd1);
  endtask

  task automatic compare_out(input string tag);
    int nbad = 0;
    chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_data"}, 64'(nbad), 64'd0);
    out_q.delete(); exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_v), 64'd0);
    chk("rst_tready", 64'(s_rdy), 64'd0);
    chk("rst_tdata", 64'(m_d[63:0] | 64'(m_l)), 64'd0);
    chk("rst_wcnt", 64'(wc), 64'd0);
    chk("rst_flen", 64'(fl), 64'd0);
    chk("rst_err", 64'({e_l, e_s}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Padded frame, 3 full windows, ready held high
    add_pad(SKIP); add_win(100, 1, 0); add_win(100, 1, 0); add_win(100, 1, 1);
    run_frame(0, 0);
    chk("f1_cycles", 64'(cyc), 64'd352);
    compare_out("f1");
    @(negedge clk);
    chk("f1_flen", 64'(fl), 64'd350);
    chk("f1_wcnt", 64'(wc), 64'd3);
    chk("f1_errs", 64'(n_el_seen + n_es_seen), 64'd0);

    // Same frame, downstream ready toggling
    add_pad(SKIP); add_win(100, 1, 0); add_win(100, 1, 0); add_win(100, 1, 1);
    run_frame(1, 0);
    chk("f2_hold", 64'(hold_bad), 64'd0);
    compare_out("f2");
    @(negedge clk) m_rdy = 1'b1;
    chk("f2_flen", 64'(fl), 64'd350);

    // Short final window, no padding
    sel_np = 1'b1;
    add_win(100, 1, 0); add_win(37, 1, 1);
    run_frame(0, 0);
    chk("f3_cycles", 64'(cyc), 64'd139);
    compare_out("f3");
    @(negedge clk);
    chk("f3_wcnt", 64'(wc), 64'd2);
    chk("f3_flen", 64'(fl), 64'd137);
    chk("f3_errs", 64'(n_el_seen + n_es_seen), 64'd0);
    sel_np = 1'b0;

    // Short non-final window
    add_pad(SKIP); add_win(60, 1, 0); add_win(100, 1, 1);
    run_frame(0, 0);
    compare_out("f4");
    chk("f4_err_short", 64'(n_es_seen), 64'd1);
    chk("f4_err_long", 64'(n_el_seen), 64'd0);
    @(negedge clk);
    chk("f4_wcnt", 64'(wc), 64'd2);

    // 150 samples with no tlast until the frame end: forced boundary at 100
    add_pad(SKIP); add_win(150, 1, 1);
    run_frame(0, 0);
    compare_out("f5");
    chk("f5_err_long", 64'(n_el_seen), 64'd1);
    chk("f5_err_short", 64'(n_es_seen), 64'd0);
    @(negedge clk);
    chk("f5_wcnt", 64'(wc), 64'd2);
    chk("f5_flen", 64'(fl), 64'd200);

    // Reset after 120 data samples of a frame
    add_pad(SKIP); add_win(300, 1, 1);
    run_frame(0, SKIP + 120);
    @(negedge clk);
    rst_n = 1'b0; in_q.delete(); tv = 1'b0;
    @(posedge clk); #1;
    chk("mrst_tvalid", 64'(m_v), 64'd0);
    chk("mrst_tlast", 64'(m_l), 64'd0);
    chk("mrst_tdata", m_d[63:0], 64'd0);
    chk("mrst_tready", 64'(s_rdy), 64'd0);
    chk("mrst_wcnt", 64'(wc), 64'd0);
    chk("mrst_flen", 64'(fl), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    out_q.delete(); exp_q.delete();
    add_pad(SKIP); add_win(100, 1, 0); add_win(100, 1, 0); add_win(100, 1, 1);
    run_frame(0, 0);
    chk("f6_cycles", 64'(cyc), 64'd352);
    compare_out("f6");
    @(negedge clk);
    chk("f6_flen", 64'(fl), 64'd350);
    chk("f6_wcnt", 64'(wc), 64'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
